rs_dec_cw_buffer: RTL

- Multi-bank codeword delay buffer for the RS decoder datapath, replacing the fixed single-codeword DpRam.
- Holds received symbols while syndrome, key-equation and Chien stages run.
- Captures each codeword (runtime length, shortened codes supported) into a free bank and replays it as a stream when the decoder requests it.
- Provides bank-occupancy status and sticky error flags.

---
 rtl/rs_dec_cw_buffer_if.sv | 25 ++
 rtl/rs_dec_cw_buffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rs_dec_cw_buffer_if.sv
// Stream signals of the RS decoder codeword buffer: symbol capture on the
// write side, codeword replay on the read side.
interface rs_dec_cw_buffer_if #(
   parameter int SYM_W = 7
) ();
   logic             wr_valid;
   logic             wr_sof;
   logic [SYM_W-1:0] wr_data;
   logic             wr_ready;
   logic             rd_start;
   logic             rd_busy;
   logic             rd_valid;
   logic [SYM_W-1:0] rd_data;
   logic             rd_last;

   modport master (
      output wr_valid, wr_sof, wr_data, rd_start,
      input  wr_ready, rd_busy, rd_valid, rd_data, rd_last
   );

   modport slave (
      input  wr_valid, wr_sof, wr_data, rd_start,
      output wr_ready, rd_busy, rd_valid, rd_data, rd_last
   );
endinterface

// File: rtl/rs_dec_cw_buffer.sv
// Multi-bank codeword delay buffer: captures runtime-length codewords into
// free banks and replays the oldest committed bank as a gap-free stream.
module rs_dec_cw_buffer #(
   parameter int SYM_W  = 7,
   parameter int ADDR_W = 8,
   parameter int N_BANK = 2,
   parameter int BANK_W = 1
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] cfg_len_m1,
   rs_dec_cw_buffer_if.slave bus,
   output logic [BANK_W:0]   full_cnt,
   output logic              ovf_err,
   output logic              udf_err,
   output logic              sof_err
);
   localparam int              DEPTH  = N_BANK << ADDR_W;
   localparam logic [BANK_W:0] FULL_C = N_BANK[BANK_W:0];

   localparam logic       W_IDLE  = 1'b0;
   localparam logic       W_FILL  = 1'b1;
   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_RUN   = 2'd1;
   localparam logic [1:0] R_DRAIN = 2'd2;

   logic [SYM_W-1:0] mem [DEPTH];

   logic                           w_state_reg;
   logic [ADDR_W-1:0]              w_idx_reg;
   logic [BANK_W-1:0]              wr_bank_reg;
   logic                           wr_ready_reg;
   logic [N_BANK-1:0][ADDR_W-1:0]  len_reg;
   logic [BANK_W:0]                full_cnt_reg, full_cnt_next;
   logic                           ovf_err_reg, udf_err_reg, sof_err_reg;

   logic [1:0]                     r_state_reg;
   logic [ADDR_W-1:0]              ra_reg;
   logic [BANK_W-1:0]              rd_bank_reg;
   logic [BANK_W+ADDR_W-1:0]       raddr_reg;
   logic                           v1_reg, last1_reg;
   logic                           rd_busy_reg, rd_valid_reg, rd_last_reg;
   logic [SYM_W-1:0]               rd_data_reg;

   logic                           wr_acc, sof_acc, dat_acc, commit, rel_bank;
   logic                           rd_go, rd_bad, mem_we;
   logic [ADDR_W-1:0]              len_wr, len_rd, w_idx_sel;
   logic [BANK_W+ADDR_W-1:0]       mem_waddr;

   assign wr_acc    = bus.wr_valid & wr_ready_reg;
   assign sof_acc   = wr_acc & bus.wr_sof;
   assign dat_acc   = wr_acc & ~bus.wr_sof & (w_state_reg == W_FILL);
   assign len_wr    = len_reg[wr_bank_reg];
   assign len_rd    = len_reg[rd_bank_reg];
   assign commit    = (sof_acc & (cfg_len_m1 == '0)) | (dat_acc & (w_idx_reg == len_wr));
   // The bank is freed on the edge that presents its final symbol.
   assign rel_bank  = v1_reg & last1_reg;
   assign mem_we    = sof_acc | dat_acc;
   assign w_idx_sel = sof_acc ? '0 : w_idx_reg;
   assign mem_waddr = {wr_bank_reg, w_idx_sel};
   assign rd_go     = bus.rd_start & (r_state_reg == R_IDLE) & (full_cnt_reg != '0);
   assign rd_bad    = bus.rd_start & ~rd_go;

   always_comb begin
      full_cnt_next = full_cnt_reg;
      if (commit && !rel_bank)
         full_cnt_next = full_cnt_reg + 1'b1;
      else if (!commit && rel_bank)
         full_cnt_next = full_cnt_reg - 1'b1;
   end

   always_ff @(posedge clock) begin
      if (mem_we)
         mem[mem_waddr] <= bus.wr_data;
   end

   for (genvar gi = 0; gi < N_BANK; gi++) begin : g_len
      logic [ADDR_W-1:0] len_q;
      always_ff @(posedge clock or negedge rst_n) begin
         if (!rst_n)
            len_q <= '0;
         else if (sof_acc && (wr_bank_reg == BANK_W'(gi)))
            len_q <= cfg_len_m1;
      end
      assign len_reg[gi] = len_q;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         w_state_reg  <= W_IDLE;
         w_idx_reg    <= '0;
         wr_bank_reg  <= '0;
         wr_ready_reg <= 1'b0;
         full_cnt_reg <= '0;
         ovf_err_reg  <= 1'b0;
         sof_err_reg  <= 1'b0;
      end else begin
         full_cnt_reg <= full_cnt_next;
         wr_ready_reg <= (full_cnt_next < FULL_C);
         if (bus.wr_valid && !wr_ready_reg)
            ovf_err_reg <= 1'b1;
         if (sof_acc && (w_state_reg == W_FILL))
            sof_err_reg <= 1'b1;
         // A restart SOF reuses the same bank; only a commit advances it.
         if (commit) begin
            w_state_reg <= W_IDLE;
            w_idx_reg   <= '0;
            wr_bank_reg <= wr_bank_reg + 1'b1;
         end else if (sof_acc) begin
            w_state_reg <= W_FILL;
            w_idx_reg   <= ADDR_W'(1);
         end else if (dat_acc) begin
            w_idx_reg   <= w_idx_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_state_reg  <= R_IDLE;
         ra_reg       <= '0;
         rd_bank_reg  <= '0;
         raddr_reg    <= '0;
         v1_reg       <= 1'b0;
         last1_reg    <= 1'b0;
         rd_busy_reg  <= 1'b0;
         rd_valid_reg <= 1'b0;
         rd_last_reg  <= 1'b0;
         rd_data_reg  <= '0;
         udf_err_reg  <= 1'b0;
      end else begin
         if (rd_bad)
            udf_err_reg <= 1'b1;
         v1_reg    <= (r_state_reg == R_RUN);
         last1_reg <= (r_state_reg == R_RUN) && (ra_reg == len_rd);
         if (r_state_reg == R_RUN)
            raddr_reg <= {rd_bank_reg, ra_reg};
         rd_valid_reg <= v1_reg;
         rd_last_reg  <= rel_bank;
         if (v1_reg)
            rd_data_reg <= mem[raddr_reg];
         if (rel_bank)
            rd_bank_reg <= rd_bank_reg + 1'b1;
         case (r_state_reg)
            R_IDLE: begin
               if (rd_go) begin
                  r_state_reg <= R_RUN;
                  rd_busy_reg <= 1'b1;
                  ra_reg      <= '0;
               end
            end
            R_RUN: begin
               if (ra_reg == len_rd)
                  r_state_reg <= R_DRAIN;
               else
                  ra_reg <= ra_reg + 1'b1;
            end
            R_DRAIN: begin
               if (rd_last_reg) begin
                  r_state_reg <= R_IDLE;
                  rd_busy_reg <= 1'b0;
               end
            end
            default: r_state_reg <= R_IDLE;
         endcase
      end
   end

   assign bus.wr_ready = wr_ready_reg;
   assign bus.rd_busy  = rd_busy_reg;
   assign bus.rd_valid = rd_valid_reg;
   assign bus.rd_data  = rd_data_reg;
   assign bus.rd_last  = rd_last_reg;
   assign full_cnt     = full_cnt_reg;
   assign ovf_err      = ovf_err_reg;
   assign udf_err      = udf_err_reg;
   assign sof_err      = sof_err_reg;
endmodule
